// File: rtl/router_pkg.sv
// Shared constants and types for the 1-to-8 router.
package router_pkg;
   localparam int N_OUT = 8;
   localparam int SEL_W = 3;
   localparam int CNT_W = 16;

   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/router_onehot_dec.sv
// Combinational 3-to-8 one-hot decoder gated by enable; drives both the
// next lane-valid flags and the per-lane write strobes.
module router_onehot_dec
   import router_pkg::*;
(
   input  logic             enable,
   input  sel_t             s,
   output logic [N_OUT-1:0] valid_nxt,
   output logic [N_OUT-1:0] lane_we
);

   always_comb begin
      valid_nxt = '0;
      if (enable) begin
         valid_nxt[s] = 1'b1;
      end
   end

   // A lane is written exactly when its valid flag will be set.
   assign lane_we = valid_nxt;

endmodule

// File: rtl/router_1_to_8.sv
// Registered 1-to-8 demux router, one cycle latency. Define ROUTER_CNT_EN to
// add saturating per-lane route counters on port route_cnt.
module router_1_to_8
   import router_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       x,
   input  logic                    enable,
   input  logic [2:0]              s,
   output logic [8*DATA_W-1:0]     y,
   output logic [7:0]              y_valid
`ifdef ROUTER_CNT_EN
   ,
   output logic [8*16-1:0]         route_cnt
`endif
);

   logic [N_OUT-1:0]        valid_nxt_p0;
   logic [N_OUT-1:0]        lane_we_p0;
   logic [N_OUT*DATA_W-1:0] y_nxt_p0;

   logic [N_OUT*DATA_W-1:0] y_p1;
   logic [N_OUT-1:0]        vld_p1;

   router_onehot_dec u_dec (
      .enable    (enable),
      .s         (sel_t'(s)),
      .valid_nxt (valid_nxt_p0),
      .lane_we   (lane_we_p0)
   );

   // Stage p0: steer x into the selected lane, zero everywhere else.
   always_comb begin
      y_nxt_p0 = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (lane_we_p0[k]) begin
            y_nxt_p0[k*DATA_W +: DATA_W] = x;
         end
      end
   end

   // Stage p1: output registers; reset clears data too so idle lanes read zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_p1   <= '0;
         vld_p1 <= '0;
      end else begin
         y_p1   <= y_nxt_p0;
         vld_p1 <= valid_nxt_p0;
      end
   end

   assign y       = y_p1;
   assign y_valid = vld_p1;

`ifdef ROUTER_CNT_EN
   logic [CNT_W-1:0] cnt_p1 [N_OUT];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) begin
            cnt_p1[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (lane_we_p0[k]) begin
               cnt_p1[k] <= sat_inc(cnt_p1[k]);
            end
         end
      end
   end

   always_comb begin
      route_cnt = '0;
      for (int k = 0; k < N_OUT; k++) begin
         route_cnt[k*CNT_W +: CNT_W] = cnt_p1[k];
      end
   end
`endif

endmodule

// File: tb/tb_router_1_to_8.sv
// Directed table-driven bench for router_1_to_8 with DATA_W=1.
module tb_router_1_to_8;

   logic       clk;
   logic       rst;
   logic [0:0] x;
   logic       enable;
   logic [2:0] s;
   logic [7:0] y;
   logic [7:0] y_valid;
`ifdef ROUTER_CNT_EN
   logic [127:0] route_cnt;
`endif

   int total;
   int bad;

   router_1_to_8 #(.DATA_W(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .x       (x),
      .enable  (enable),
      .s       (s),
      .y       (y),
      .y_valid (y_valid)
`ifdef ROUTER_CNT_EN
      ,
      .route_cnt (route_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] sel;
      logic       xin;
      logic [7:0] exp_y;
      logic [7:0] exp_v;
      string      name;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_and_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      x      = 1'b0;
      enable = 1'b0;
      s      = 3'd0;

      vecs[0]  = '{1'b1, 3'd0, 1'b1, 8'h01, 8'h01, "sweep_s0"};
      vecs[1]  = '{1'b1, 3'd1, 1'b1, 8'h02, 8'h02, "sweep_s1"};
      vecs[2]  = '{1'b1, 3'd2, 1'b1, 8'h04, 8'h04, "sweep_s2"};
      vecs[3]  = '{1'b1, 3'd3, 1'b1, 8'h08, 8'h08, "sweep_s3"};
      vecs[4]  = '{1'b1, 3'd4, 1'b1, 8'h10, 8'h10, "sweep_s4"};
      vecs[5]  = '{1'b1, 3'd5, 1'b1, 8'h20, 8'h20, "sweep_s5"};
      vecs[6]  = '{1'b1, 3'd6, 1'b1, 8'h40, 8'h40, "sweep_s6"};
      vecs[7]  = '{1'b1, 3'd7, 1'b1, 8'h80, 8'h80, "sweep_s7"};
      vecs[8]  = '{1'b0, 3'd1, 1'b1, 8'h00, 8'h00, "disable_s1"};
      vecs[9]  = '{1'b1, 3'd4, 1'b1, 8'h10, 8'h10, "reenable_s4"};
      vecs[10] = '{1'b1, 3'd6, 1'b0, 8'h00, 8'h40, "zero_data_s6"};
      vecs[11] = '{1'b0, 3'd7, 1'b1, 8'h00, 8'h00, "disable_s7"};
      vecs[12] = '{1'b1, 3'd0, 1'b0, 8'h00, 8'h01, "zero_data_s0"};
      vecs[13] = '{1'b1, 3'd7, 1'b1, 8'h80, 8'h80, "back_to_back_s7"};

      // Reset held across edges
      edge_and_settle();
      edge_and_settle();
      check("reset_y", y, 8'h00);
      check("reset_v", y_valid, 8'h00);

      // Route once, then assert reset between edges
      rst = 1'b0;
      enable = 1'b1; s = 3'd5; x = 1'b1;
      edge_and_settle();
      check("pre_reset_y", y, 8'h20);
      #2 rst = 1'b1;
      #1;
      check("async_reset_y", y, 8'h00);
      check("async_reset_v", y_valid, 8'h00);
      rst = 1'b0;
      #1;
      check("released_no_edge_y", y, 8'h00);
      check("released_no_edge_v", y_valid, 8'h00);

      // Table sweep
      for (int i = 0; i < 14; i++) begin
         enable = vecs[i].en;
         s      = vecs[i].sel;
         x      = vecs[i].xin;
         edge_and_settle();
         check({vecs[i].name, "_y"}, y, vecs[i].exp_y);
         check({vecs[i].name, "_v"}, y_valid, vecs[i].exp_v);
      end

      // Select changes between edges do not disturb registered outputs
      enable = 1'b1; x = 1'b1; s = 3'd1;
      edge_and_settle();
      s = 3'd6;
      #2;
      check("mid_cycle_sel_y", y, 8'h02);
      edge_and_settle();
      check("sampled_sel_y", y, 8'h40);

      // Mid-stream reset
      s = 3'd7;
      edge_and_settle();
      check("stream_s7_y", y, 8'h80);
      #2 rst = 1'b1;
      #1;
      check("midstream_rst_y", y, 8'h00);
      check("midstream_rst_v", y_valid, 8'h00);
      rst = 1'b0;
      s = 3'd2;
      edge_and_settle();
      check("resume_s2_y", y, 8'h04);
      check("resume_s2_v", y_valid, 8'h04);

`ifdef ROUTER_CNT_EN
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      check("cnt_reset", route_cnt, 128'h0);
      enable = 1'b1; s = 3'd3;
      for (int i = 0; i < 5; i++) edge_and_settle();
      enable = 1'b0;
      for (int i = 0; i < 2; i++) edge_and_settle();
      check("cnt_lane3_five", route_cnt, 128'd5 << 48);

      #2 rst = 1'b1;
      #1 rst = 1'b0;
      enable = 1'b1; s = 3'd3;
      for (int i = 0; i < 65535; i++) edge_and_settle();
      check("cnt_lane3_full", route_cnt, 128'hFFFF << 48);
      edge_and_settle();
      edge_and_settle();
      check("cnt_lane3_saturated", route_cnt, 128'hFFFF << 48);
      enable = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
